// File: rtl/mem_port_arb.sv
// mem_port_arb
//   Owns the port-multiplex bit (mp) of the dual-port data memory and schedules the
//   pipeline MA/MO access and a secondary DMA/debug requester onto it. The address
//   of the access granted in cycle N is registered into port ~mp, which becomes the
//   data port in N+1, so every granted access completes exactly one cycle later.
//   The pipeline has priority. After STARVE_MAX consecutive DMA denials, the DMA is
//   forced through and the pipeline is stalled for one cycle.
//
// Optional feature: define MEM_ARB_STATS_EN to add the saturating statistics counters
//   ow_stat_dma_cnt (DMA grants) and ow_stat_force_cnt (forced pipeline stalls).
//
// Ports
//   iw_clk, iw_rst                   clock, asynchronous active-high reset
//   iw_pl_*                          pipeline request (req/we/addr/wdata)
//   ow_pl_stall                      pipeline must hold MA this cycle
//   ow_pl_rvalid, ow_pl_rdata        pipeline load data (data phase)
//   iw_dma_*                         DMA request, held until granted
//   ow_dma_gnt                       DMA request accepted this cycle
//   ow_dma_rvalid, ow_dma_rdata      DMA load data (data phase)
//   ow_mem_mp                        port used for the data phase this cycle
//   ow_mem_addr_0, ow_mem_addr_1     registered port addresses
//   ow_mem_we, ow_mem_wdata          write strobe/data on port ow_mem_mp
//   iw_mem_rdata                     read data from port ow_mem_mp
//   ow_stat_dma_cnt, ow_stat_force_cnt   statistics (MEM_ARB_STATS_EN only)

module mem_port_arb #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 24,
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 4
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_pl_req,
    input  logic              iw_pl_we,
    input  logic [ADDR_W-1:0] iw_pl_addr,
    input  logic [DATA_W-1:0] iw_pl_wdata,
    output logic              ow_pl_stall,
    output logic              ow_pl_rvalid,
    output logic [DATA_W-1:0] ow_pl_rdata,
    input  logic              iw_dma_req,
    input  logic              iw_dma_we,
    input  logic [ADDR_W-1:0] iw_dma_addr,
    input  logic [DATA_W-1:0] iw_dma_wdata,
    output logic              ow_dma_gnt,
    output logic              ow_dma_rvalid,
    output logic [DATA_W-1:0] ow_dma_rdata,
    output logic              ow_mem_mp,
    output logic [ADDR_W-1:0] ow_mem_addr_0,
    output logic [ADDR_W-1:0] ow_mem_addr_1,
    output logic              ow_mem_we,
    output logic [DATA_W-1:0] ow_mem_wdata,
`ifdef MEM_ARB_STATS_EN
    output logic [15:0]       ow_stat_dma_cnt,
    output logic [15:0]       ow_stat_force_cnt,
`endif
    input  logic [DATA_W-1:0] iw_mem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic              mp_q, mp_d;
    logic [ADDR_W-1:0] addr_0_q, addr_0_d;
    logic [ADDR_W-1:0] addr_1_q, addr_1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              owner_q, owner_d;     // 1 = DMA owns the data phase
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              starved;
    logic              dma_gnt;
    logic              pl_gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_we;
    logic [DATA_W-1:0] acc_wdata;

    // Arbitration and next-state
    always_comb begin
        starved   = (cnt_q == STARVE_LIM);
        // Arbitration is held off while in reset so every output reads 0 there.
        dma_gnt   = !iw_rst && iw_dma_req && (!iw_pl_req || starved);
        pl_gnt    = !iw_rst && iw_pl_req && !dma_gnt;
        any_gnt   = dma_gnt || pl_gnt;
        acc_addr  = dma_gnt ? iw_dma_addr  : iw_pl_addr;
        acc_we    = dma_gnt ? iw_dma_we    : iw_pl_we;
        acc_wdata = dma_gnt ? iw_dma_wdata : iw_pl_wdata;

        mp_d     = ~mp_q;
        addr_0_d = addr_0_q;
        addr_1_d = addr_1_q;
        // The granted address goes to the port that becomes the data port next cycle.
        if (any_gnt) begin
            if (mp_q) begin
                addr_0_d = acc_addr;
            end else begin
                addr_1_d = acc_addr;
            end
        end

        valid_d = any_gnt;
        owner_d = dma_gnt;
        we_d    = any_gnt && acc_we;
        wdata_d = (any_gnt && acc_we) ? acc_wdata : '0;

        if (!iw_dma_req || dma_gnt) begin
            cnt_d = '0;
        end else if (!starved) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            mp_q     <= 1'b0;
            addr_0_q <= '0;
            addr_1_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            mp_q     <= mp_d;
            addr_0_q <= addr_0_d;
            addr_1_q <= addr_1_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    // Data phase outputs; read data is gated so idle cycles present zeros.
    always_comb begin
        ow_pl_stall   = !iw_rst && iw_pl_req && dma_gnt;
        ow_dma_gnt    = dma_gnt;
        ow_mem_mp     = mp_q;
        ow_mem_addr_0 = addr_0_q;
        ow_mem_addr_1 = addr_1_q;
        ow_mem_we     = valid_q && we_q;
        ow_mem_wdata  = ow_mem_we ? wdata_q : '0;
        ow_pl_rvalid  = valid_q && !we_q && !owner_q;
        ow_dma_rvalid = valid_q && !we_q && owner_q;
        ow_pl_rdata   = ow_pl_rvalid  ? iw_mem_rdata : '0;
        ow_dma_rdata  = ow_dma_rvalid ? iw_mem_rdata : '0;
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_dma_q, stat_dma_d;
    logic [15:0] stat_force_q, stat_force_d;

    always_comb begin
        stat_dma_d   = stat_dma_q;
        stat_force_d = stat_force_q;
        if (dma_gnt && stat_dma_q != 16'hFFFF) begin
            stat_dma_d = stat_dma_q + 16'd1;
        end
        if (dma_gnt && iw_pl_req && stat_force_q != 16'hFFFF) begin
            stat_force_d = stat_force_q + 16'd1;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            stat_dma_q   <= '0;
            stat_force_q <= '0;
        end else begin
            stat_dma_q   <= stat_dma_d;
            stat_force_q <= stat_force_d;
        end
    end

    assign ow_stat_dma_cnt   = stat_dma_q;
    assign ow_stat_force_cnt = stat_force_q;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed testbench for mem_port_arb with a scoreboard of expected data phases.
module tb_mem_port_arb;

    localparam int STARVE_MAX = 8;

    logic        iw_clk = 1'b0;
    logic        iw_rst;
    logic        iw_pl_req, iw_pl_we;
    logic [23:0] iw_pl_addr, iw_pl_wdata;
    logic        ow_pl_stall, ow_pl_rvalid;
    logic [23:0] ow_pl_rdata;
    logic        iw_dma_req, iw_dma_we;
    logic [23:0] iw_dma_addr, iw_dma_wdata;
    logic        ow_dma_gnt, ow_dma_rvalid;
    logic [23:0] ow_dma_rdata;
    logic        ow_mem_mp;
    logic [23:0] ow_mem_addr_0, ow_mem_addr_1;
    logic        ow_mem_we;
    logic [23:0] ow_mem_wdata;
    logic [23:0] iw_mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] ow_stat_dma_cnt, ow_stat_force_cnt;
`endif

    mem_port_arb #(.ADDR_W(24), .DATA_W(24), .STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .iw_pl_req(iw_pl_req), .iw_pl_we(iw_pl_we), .iw_pl_addr(iw_pl_addr),
        .iw_pl_wdata(iw_pl_wdata), .ow_pl_stall(ow_pl_stall),
        .ow_pl_rvalid(ow_pl_rvalid), .ow_pl_rdata(ow_pl_rdata),
        .iw_dma_req(iw_dma_req), .iw_dma_we(iw_dma_we), .iw_dma_addr(iw_dma_addr),
        .iw_dma_wdata(iw_dma_wdata), .ow_dma_gnt(ow_dma_gnt),
        .ow_dma_rvalid(ow_dma_rvalid), .ow_dma_rdata(ow_dma_rdata),
        .ow_mem_mp(ow_mem_mp), .ow_mem_addr_0(ow_mem_addr_0), .ow_mem_addr_1(ow_mem_addr_1),
        .ow_mem_we(ow_mem_we), .ow_mem_wdata(ow_mem_wdata),
`ifdef MEM_ARB_STATS_EN
        .ow_stat_dma_cnt(ow_stat_dma_cnt), .ow_stat_force_cnt(ow_stat_force_cnt),
`endif
        .iw_mem_rdata(iw_mem_rdata)
    );

    always #5 iw_clk = ~iw_clk;

    typedef struct {
        logic        valid;
        logic        owner;   // 1 = DMA
        logic        we;
        logic [23:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err = 0;
    logic        mp_m;
    int          cnt_m;
    logic [23:0] addr0_m, addr1_m;
    int          stat_dma_m, stat_force_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        sb.delete();
        mp_m = 1'b0; cnt_m = 0; addr0_m = '0; addr1_m = '0;
        stat_dma_m = 0; stat_force_m = 0;
    endtask

    task automatic push_idle();
        exp_t e;
        e.valid = 1'b0; e.owner = 1'b0; e.we = 1'b0; e.wdata = '0;
        sb.push_back(e);
    endtask

    // One cycle: drive inputs at the negedge, check the data phase due from the
    // previous grant, check and record this cycle's grant, advance to next negedge.
    task automatic step(input logic pr, input logic pw, input logic [23:0] pa, input logic [23:0] pd,
                        input logic dr, input logic dw, input logic [23:0] da, input logic [23:0] dd);
        exp_t        e, n;
        logic [23:0] rd;
        logic        g, plg, exp_we, exp_plr, exp_dmr;
        iw_pl_req = pr; iw_pl_we = pw; iw_pl_addr = pa; iw_pl_wdata = pd;
        iw_dma_req = dr; iw_dma_we = dw; iw_dma_addr = da; iw_dma_wdata = dd;
        rd = 24'($urandom);
        iw_mem_rdata = rd;
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            exp_we  = e.valid && e.we;
            exp_plr = e.valid && !e.we && !e.owner;
            exp_dmr = e.valid && !e.we && e.owner;
            chk("mp", ow_mem_mp, mp_m);
            chk("mem_we", ow_mem_we, exp_we);
            chk("mem_wdata", ow_mem_wdata, exp_we ? e.wdata : 24'h0);
            chk("pl_rvalid", ow_pl_rvalid, exp_plr);
            chk("pl_rdata", ow_pl_rdata, exp_plr ? rd : 24'h0);
            chk("dma_rvalid", ow_dma_rvalid, exp_dmr);
            chk("dma_rdata", ow_dma_rdata, exp_dmr ? rd : 24'h0);
            chk("addr_0", ow_mem_addr_0, addr0_m);
            chk("addr_1", ow_mem_addr_1, addr1_m);
        end
        g   = dr && (!pr || cnt_m == STARVE_MAX);
        plg = pr && !g;
        chk("dma_gnt", ow_dma_gnt, g);
        chk("pl_stall", ow_pl_stall, pr && g);
        n.valid = g || plg;
        n.owner = g;
        n.we    = g ? dw : pw;
        n.wdata = g ? dd : pd;
        sb.push_back(n);
        if (g || plg) begin
            if (mp_m) addr0_m = g ? da : pa;
            else      addr1_m = g ? da : pa;
        end
        if (!dr || g) cnt_m = 0;
        else if (cnt_m < STARVE_MAX) cnt_m++;
        if (g) stat_dma_m++;
        if (g && pr) stat_force_m++;
        mp_m = !mp_m;
        @(negedge iw_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 24'h0, 24'h0, 0, 0, 24'h0, 24'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        iw_rst = 1'b1;
        iw_pl_req = 0; iw_pl_we = 0; iw_pl_addr = '0; iw_pl_wdata = '0;
        iw_dma_req = 0; iw_dma_we = 0; iw_dma_addr = '0; iw_dma_wdata = '0;
        iw_mem_rdata = 24'h5A5A5A;
        reset_model();
        repeat (2) @(negedge iw_clk);
        chk("rst_mp", ow_mem_mp, 1'b0);
        chk("rst_we", ow_mem_we, 1'b0);
        chk("rst_pl_rvalid", ow_pl_rvalid, 1'b0);
        chk("rst_addr_1", ow_mem_addr_1, 24'h0);
`ifdef MEM_ARB_STATS_EN
        chk("rst_stat_dma", ow_stat_dma_cnt, 16'h0);
`endif
        iw_rst = 1'b0;
        push_idle();

        // Idle after reset: mp 0,1,0,1 with nothing active
        idle(4);

        // Pipeline load at 0x10 (mp=0), then a store and a back-to-back load
        step(1, 0, 24'h000010, 24'h0, 0, 0, 24'h0, 24'h0);
        step(1, 1, 24'h000030, 24'h00BEEF, 0, 0, 24'h0, 24'h0);
        step(1, 0, 24'h000030, 24'h0, 0, 0, 24'h0, 24'h0);
        idle(1);

        // DMA store and DMA load with no pipeline traffic
        step(0, 0, 24'h0, 24'h0, 1, 1, 24'h000020, 24'h00ABCD);
        step(0, 0, 24'h0, 24'h0, 1, 0, 24'h000024, 24'h0);
        idle(2);

        // Starvation: both held for 12 cycles; forced DMA grant on cycle 8
        for (int i = 0; i < 12; i++)
            step(1, i[0], 24'h000100 + 24'(i), 24'h000700 + 24'(i), 1, 0, 24'h000200, 24'h0);
        idle(2);
`ifdef MEM_ARB_STATS_EN
        chk("stat_force_cnt", ow_stat_force_cnt, 16'(stat_force_m));
        chk("stat_dma_cnt", ow_stat_dma_cnt, 16'(stat_dma_m));
`endif

        // Async reset in the data phase of a granted store
        step(1, 1, 24'h000040, 24'h123456, 0, 0, 24'h0, 24'h0);
        iw_pl_req = 0; iw_pl_we = 0;
        #1;
        chk("pre_rst_we", ow_mem_we, 1'b1);
        iw_rst = 1'b1;
        #1;
        chk("rst_drop_we", ow_mem_we, 1'b0);
        chk("rst_drop_wdata", ow_mem_wdata, 24'h0);
        chk("rst_drop_mp", ow_mem_mp, 1'b0);
        chk("rst_drop_addr_0", ow_mem_addr_0, 24'h0);
        reset_model();
        @(negedge iw_clk);
        @(negedge iw_clk);
        iw_rst = 1'b0;
        push_idle();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
